// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes. One setup cycle plus WIDTH iterations per operation.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               prep_reg;
    logic               is_mul_reg;
    logic               neg_reg;
    logic               bzero_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   m_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [TAG_W-1:0]   tag_lat_reg;
    logic               busy_reg;
    logic               rdy_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               exc_reg;
    logic [TAG_W-1:0]   tag_out_reg;

    logic               start;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   rem_shift;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quot_signed;
    logic [WIDTH-1:0]   sext_ok;
    logic               mul_ovf;
    logic               div_ovf;
    logic [WIDTH-1:0]   fin_result;
    logic               fin_exc;

    assign start = ctrl_mult | ctrl_div;

    always_comb begin
        mag_a = a_reg[WIDTH-1] ? -a_reg : a_reg;
        mag_b = b_reg[WIDTH-1] ? -b_reg : b_reg;

        // Multiply: accumulator high half gathers partial sums, low half holds
        // the remaining multiplier bits; both shift right each iteration.
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, m_reg} : '0);
        mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

        // Divide: high half is the partial remainder (always < divisor <= 2^(WIDTH-1),
        // so its top bit is zero), low half shifts dividend out / quotient in.
        rem_shift = {acc_reg[2*WIDTH-2:WIDTH], acc_reg[WIDTH-1]};
        trial     = {1'b0, rem_shift} - {1'b0, m_reg};
        div_next  = trial[WIDTH] ? {rem_shift, acc_reg[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

        step_acc    = is_mul_reg ? mul_next : div_next;
        prod_signed = neg_reg ? -step_acc : step_acc;
        quot_signed = neg_reg ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
    end

    // The product fits WIDTH signed bits only if every upper bit repeats bit WIDTH-1.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sext
            assign sext_ok[gi] = (prod_signed[WIDTH+gi] == prod_signed[WIDTH-1]);
        end
    endgenerate

    assign mul_ovf = ~&sext_ok;
    // A positive quotient with the top magnitude bit set is only -2^(WIDTH-1) / -1.
    assign div_ovf = ~neg_reg & step_acc[WIDTH-1];

    always_comb begin
        fin_result = '0;
        fin_exc    = 1'b0;
        if (is_mul_reg) begin
            fin_result = prod_signed[WIDTH-1:0];
            fin_exc    = mul_ovf;
        end else if (bzero_reg) begin
            fin_result = '0;
            fin_exc    = 1'b1;
        end else begin
            fin_result = quot_signed;
            fin_exc    = div_ovf;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            prep_reg    <= 1'b0;
            is_mul_reg  <= 1'b0;
            neg_reg     <= 1'b0;
            bzero_reg   <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            m_reg       <= '0;
            acc_reg     <= '0;
            tag_lat_reg <= '0;
            busy_reg    <= 1'b0;
            rdy_reg     <= 1'b0;
            result_reg  <= '0;
            exc_reg     <= 1'b0;
            tag_out_reg <= '0;
        end else begin
            rdy_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg   <= S_RUN;
                        busy_reg    <= 1'b1;
                        count_reg   <= '0;
                        prep_reg    <= 1'b1;
                        is_mul_reg  <= ctrl_mult;
                        a_reg       <= operand_a;
                        b_reg       <= operand_b;
                        tag_lat_reg <= tag_in;
                    end else begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (prep_reg) begin
                        // Setup cycle: take magnitudes so the iterations work unsigned.
                        prep_reg  <= 1'b0;
                        acc_reg   <= is_mul_reg ? {{WIDTH{1'b0}}, mag_b} : {{WIDTH{1'b0}}, mag_a};
                        m_reg     <= is_mul_reg ? mag_a : mag_b;
                        neg_reg   <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
                        bzero_reg <= (b_reg == '0);
                    end else begin
                        acc_reg   <= step_acc;
                        count_reg <= count_reg + CNT_W'(1);
                        if (count_reg == CNT_W'(WIDTH - 1)) begin
                            state_reg   <= S_DONE;
                            busy_reg    <= 1'b0;
                            rdy_reg     <= 1'b1;
                            result_reg  <= fin_result;
                            exc_reg     <= fin_exc;
                            tag_out_reg <= tag_lat_reg;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign result_rdy = rdy_reg;
    assign result     = result_reg;
    assign exception  = exc_reg;
    assign tag_out    = tag_out_reg;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: vector table driven through a scoreboard
// queue, plus sequences for reset abort, back-to-back issue and ignored starts.
module tb_multdiv_unit;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int LAT   = WIDTH + 1;

    logic             clock;
    logic             reset;
    logic             ctrl_mult;
    logic             ctrl_div;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [TAG_W-1:0] tag_in;
    logic             busy;
    logic             result_rdy;
    logic [WIDTH-1:0] result;
    logic             exception;
    logic [TAG_W-1:0] tag_out;

    multdiv_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .ctrl_mult  (ctrl_mult),
        .ctrl_div   (ctrl_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .tag_in     (tag_in),
        .busy       (busy),
        .result_rdy (result_rdy),
        .result     (result),
        .exception  (exception),
        .tag_out    (tag_out)
    );

    typedef struct {
        logic             is_mul;
        logic             both;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] exp_res;
        logic             exp_exc;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             exc;
        logic [TAG_W-1:0] tag;
        int               start_edge;
    } sb_t;

    sb_t  exp_q[$];
    int   tests     = 0;
    int   failures  = 0;
    int   cycle     = 0;
    int   rdy_count = 0;
    int   last_rdy  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: pop one scoreboard entry per result_rdy pulse.
    always @(negedge clock) begin
        if (!reset && result_rdy) begin
            sb_t e;
            rdy_count++;
            last_rdy = cycle;
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("exception", exception, e.exc);
                check("tag_out", tag_out, e.tag);
                check("latency", cycle - e.start_edge, LAT);
                check("busy_in_done", busy, 0);
                $display("[TB] rdy cycle %0d result=%08h exc=%0b tag=%0d", cycle, result, exception, tag_out);
            end
        end
    end

    // Caller is positioned just after a falling edge; start is sampled on the next rising edge.
    task automatic issue(input logic is_mul, input logic both, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                         input logic [WIDTH-1:0] exp_res, input logic exp_exc);
        sb_t e;
        ctrl_mult = is_mul | both;
        ctrl_div  = ~is_mul | both;
        operand_a = a;
        operand_b = b;
        tag_in    = tag;
        e.res = exp_res;
        e.exc = exp_exc;
        e.tag = tag;
        e.start_edge = cycle + 1;
        exp_q.push_back(e);
        @(negedge clock);
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        tag_in    = TAG_W'($urandom);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
        check("drain_timeout", exp_q.size(), 0);
        @(negedge clock);
    endtask

    task automatic wait_rdy(output int at);
        int i;
        at = -1;
        for (i = 0; i < 60; i++) begin
            @(negedge clock);
            if (result_rdy) begin
                at = cycle;
                break;
            end
        end
        check("wait_rdy_timeout", (at < 0), 0);
    endtask

    vec_t vecs[15];
    int   r0, r1, rc;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'd6,          -32'sd7,        5'd8,  32'hFFFF_FFD6, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h7FFF_FFFF,  32'd2,          5'd1,  32'hFFFF_FFFE, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'd100,        32'd7,          5'd2,  32'd14,        1'b0};
        vecs[3]  = '{1'b0, 1'b0, -32'sd100,      32'd7,          5'd3,  32'hFFFF_FFF2, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'd12,         32'd0,          5'd4,  32'd0,         1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd5,  32'h8000_0000, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h8000_0000,  32'd1,          5'd6,  32'h8000_0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000,  5'd9,  32'd0,         1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd10, 32'd1,         1'b0};
        vecs[10] = '{1'b0, 1'b0, -32'sd7,        32'd2,          5'd11, 32'hFFFF_FFFD, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'd7,          -32'sd2,        5'd12, 32'hFFFF_FFFD, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h8000_0000,  32'd1,          5'd13, 32'h8000_0000, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 32'd5,          32'd3,          5'd14, 32'd15,        1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'd0,          -32'sd1,        5'd31, 32'd0,         1'b0};

        reset = 1'b1; ctrl_mult = 1'b0; ctrl_div = 1'b0;
        operand_a = '0; operand_b = '0; tag_in = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", busy, 0);
        check("reset_rdy", result_rdy, 0);
        check("reset_result", result, 0);
        check("reset_exception", exception, 0);
        check("reset_tag", tag_out, 0);
        reset = 1'b0;
        @(negedge clock);

        foreach (vecs[i]) begin
            $display("[TB] vec %0d mul=%0b a=%08h b=%08h", i, vecs[i].is_mul, vecs[i].a, vecs[i].b);
            issue(vecs[i].is_mul, vecs[i].both, vecs[i].a, vecs[i].b, vecs[i].tag,
                  vecs[i].exp_res, vecs[i].exp_exc);
            drain();
        end

        // Reset ten cycles into a multiply aborts it without a result.
        issue(1'b1, 1'b0, 32'd7, 32'd9, 5'd20, 32'd63, 1'b0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        rc = rdy_count;
        repeat (40) @(negedge clock);
        check("abort_no_rdy", rdy_count - rc, 0);
        $display("[TB] abort sequence done");
        issue(1'b1, 1'b0, 32'd3, 32'd4, 5'd21, 32'd12, 1'b0);
        drain();

        // Divide issued during the DONE cycle of a multiply.
        issue(1'b1, 1'b0, 32'd2, 32'd3, 5'd22, 32'd6, 1'b0);
        wait_rdy(r0);
        issue(1'b0, 1'b0, 32'd24, 32'd4, 5'd23, 32'd6, 1'b0);
        wait_rdy(r1);
        check("b2b_gap", r1 - r0, LAT + 1);
        $display("[TB] back-to-back rdy at %0d and %0d", r0, r1);
        drain();

        // A start pulse while running is ignored.
        rc = rdy_count;
        issue(1'b1, 1'b0, 32'd2, 32'd3, 5'd24, 32'd6, 1'b0);
        repeat (5) @(negedge clock);
        ctrl_mult = 1'b1; operand_a = 32'd100; operand_b = 32'd100; tag_in = 5'd25;
        @(negedge clock);
        ctrl_mult = 1'b0;
        check("busy_ignored_start", busy, 1);
        drain();
        repeat (40) @(negedge clock);
        check("ignored_start_rdy_count", rdy_count - rc, 1);
        check("ignored_start_result", result, 6);
        $display("[TB] ignored-start sequence done");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
